// File: rtl/nes_bus_pkg.sv
// ============================================================================
// nes_bus_pkg : shared 2A03 bus register addresses, bus directions, DMA states
// Revision    : 1.0
// ============================================================================
`default_nettype none

package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/oam_dma.sv
// ============================================================================
// oam_dma  : halts the CPU and copies page $XX00-$XXFF to OAM data port $2004
// Revision : 1.0
// ============================================================================
`default_nettype none

module oam_dma
  import nes_bus_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic        bus_master,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        busy,
  output logic        done
);

  dma_state_e  state_q, state_d;
  logic        parity_q;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  latch_q, latch_d;

  logic        cpu_rdy_q, cpu_rdy_d;
  logic        bus_master_q, bus_master_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic        bus_rw_q, bus_rw_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        trigger;

  assign trigger = (cpu_rw == BUS_WRITE) && (cpu_addr == DMA_REG_ADDR);

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = ST_HALT;
        end
      end
      // parity_q is this cycle's parity; the next cycle has the opposite one
      ST_HALT:  state_d = parity_q ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        latch_d = bus_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? ST_DONE : ST_READ;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cpu_rdy_d    = (state_d == ST_IDLE) || (state_d == ST_DONE);
    bus_master_d = (state_d == ST_READ) || (state_d == ST_WRITE);
    busy_d       = (state_d == ST_HALT) || (state_d == ST_ALIGN) ||
                   (state_d == ST_READ) || (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
    bus_rw_d     = (state_d == ST_WRITE) ? BUS_WRITE : BUS_READ;
    bus_addr_d   = 16'h0000;
    bus_wdata_d  = 8'h00;
    if (state_d == ST_READ) begin
      bus_addr_d = {page_d, idx_d};
    end else if (state_d == ST_WRITE) begin
      bus_addr_d  = OAM_DATA_ADDR;
      bus_wdata_d = latch_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      parity_q     <= 1'b0;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      latch_q      <= 8'h00;
      cpu_rdy_q    <= 1'b1;
      bus_master_q <= 1'b0;
      bus_addr_q   <= 16'h0000;
      bus_rw_q     <= BUS_READ;
      bus_wdata_q  <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      parity_q     <= ~parity_q;
      page_q       <= page_d;
      idx_q        <= idx_d;
      latch_q      <= latch_d;
      cpu_rdy_q    <= cpu_rdy_d;
      bus_master_q <= bus_master_d;
      bus_addr_q   <= bus_addr_d;
      bus_rw_q     <= bus_rw_d;
      bus_wdata_q  <= bus_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign bus_master = bus_master_q;
  assign bus_addr   = bus_addr_q;
  assign bus_rw     = bus_rw_q;
  assign bus_wdata  = bus_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire
